// File: rtl/subtractor_32bits_serial.sv
// Digit-serial subtractor: computes a - b - bi one SLICE-bit digit per cycle, LSB first,
// with a registered borrow rippling between digits. Also reports borrow-out and signed overflow.
module subtractor_32bits_serial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             v
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(NSLICE - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bo_q, bo_d;
    logic             v_q, v_d;

    logic [31:0]      base;
    logic [SLICE:0]   digit;

    // Bit SLICE of the extended difference is the digit's borrow-out.
    always_comb begin
        base  = 32'(cnt_q) * SLICE;
        digit = {1'b0, a_q[base +: SLICE]} - {1'b0, b_q[base +: SLICE]}
                - {{SLICE{1'b0}}, borrow_q};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        bo_d     = bo_q;
        v_d      = v_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    state_d  = StRun;
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bi;
                    cnt_d    = '0;
                end
            end
            StRun: begin
                d_d[base +: SLICE] = digit[SLICE-1:0];
                borrow_d           = digit[SLICE];
                cnt_d              = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    // Top digit's MSB is the new sign bit of d.
                    bo_d    = digit[SLICE];
                    v_d     = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (digit[SLICE-1] ^ a_q[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            d_q      <= '0;
            bo_q     <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            bo_q     <= bo_d;
            v_q      <= v_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign d    = d_q;
    assign bo   = bo_q;
    assign v    = v_q;

endmodule

// File: tb/tb_subtractor_32bits_serial.sv
// Self-checking bench for subtractor_32bits_serial: directed vectors, multi-cycle corner
// sequences and a randomized run against an arithmetic reference model.
module tb_subtractor_32bits_serial;

    localparam int NRAND = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
    logic        bi;
    logic        busy, done, bo, v;
    logic [31:0] d;

    int checks   = 0;
    int failures = 0;

    subtractor_32bits_serial #(
        .WIDTH(32),
        .SLICE(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bi   (bi),
        .busy (busy),
        .done (done),
        .d    (d),
        .bo   (bo),
        .v    (v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        logic [31:0] d;
        logic        bo;
        logic        v;
    } vec_t;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    // Reference: {v, bo, d} from plain 33-bit arithmetic.
    function automatic logic [33:0] model(logic [31:0] x, logic [31:0] y, logic c);
        logic [32:0] r;
        logic [31:0] dd;
        r  = {1'b0, x} - {1'b0, y} - 33'(c);
        dd = r[31:0];
        return {(x[31] != y[31]) && (dd[31] != x[31]), r[32], dd};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Starts one operation from an idle DUT and waits (bounded) for done.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic ibi,
                          output logic [31:0] od, output logic obo, output logic ov,
                          output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; bi = ibi;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; bi = 1'($urandom_range(0, 1));
        lat = 0; nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        od = d; obo = bo; ov = v;
    endtask

    vec_t        vecs[7];
    logic [31:0] rd;
    logic        rbo, rv, saw;
    int          lat, nbusy, n;
    logic [33:0] expq[$];
    logic [33:0] e;
    int          accepted, seen, gap, cyc;

    initial begin
        vecs[0] = '{32'd5,         32'd3,         1'b0, 32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{32'd0,         32'd1,         1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'd1,         1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_0010, 32'd1,         1'b1, 32'h0000_000E, 1'b0, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'd0,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bi = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_d",    d,    0);
        check("reset_bo",   bo,   0);
        check("reset_v",    v,    0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bi, rd, rbo, rv, lat, nbusy);
            check($sformatf("vec%0d_d", i),  rd,  vecs[i].d);
            check($sformatf("vec%0d_bo", i), rbo, vecs[i].bo);
            check($sformatf("vec%0d_v", i),  rv,  vecs[i].v);
            check($sformatf("vec%0d_latency", i), lat, 8);
            check($sformatf("vec%0d_busy_cycles", i), nbusy, 8);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), done, 0);
            check($sformatf("vec%0d_d_held", i), d, vecs[i].d);
        end

        // start during RUN is ignored; start in the done cycle chains with no idle gap
        @(negedge clk);
        start = 1'b1; a = 32'd100; b = 32'd1; bi = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 32'd7; b = 32'd7; bi = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4_first_done", done, 1);
        check("t4_first_d", d, 32'd99);
        check("t4_first_bo", bo, 0);
        start = 1'b1; a = 32'd10; b = 32'd4; bi = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("t4_no_idle_busy", busy, 1);
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4_done_spacing", n, 9);
        check("t4_second_d", d, 32'd6);
        check("t4_second_bo", bo, 0);
        check("t4_second_v", v, 0);

        // asynchronous reset in the middle of an operation
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, rd, rbo, rv, lat, nbusy);
        check("t5_pre_bo", rbo, 1);
        @(negedge clk);
        start = 1'b1; a = 32'hFFFF_FFFF; b = 32'd0; bi = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_d",    d,    0);
        check("t5_rst_bo",   bo,   0);
        check("t5_rst_v",    v,    0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        check("t5_no_done_after_abort", saw, 0);
        run_op(32'h0000_1000, 32'd1, 1'b0, rd, rbo, rv, lat, nbusy);
        check("t5_after_d", rd, 32'h0000_0FFF);
        check("t5_after_latency", lat, 8);

        // randomized traffic with random gaps, including back-to-back and ignored starts
        accepted = 0; seen = 0; gap = 0; cyc = 0;
        while ((accepted < NRAND || expq.size() > 0) && cyc < NRAND * 20) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen++;
                if (expq.size() == 0) begin
                    check("rand_spurious_done", done, 0);
                end else begin
                    e = expq.pop_front();
                    check("rand_result", {v, bo, d}, e);
                end
            end
            if (!busy && accepted < NRAND) begin
                if (gap == 0) begin
                    start = 1'b1; a = pick(); b = pick(); bi = 1'($urandom_range(0, 1));
                    expq.push_back(model(a, b, bi));
                    accepted++;
                    gap = $urandom_range(0, 3);
                end else begin
                    start = 1'b0;
                    gap--;
                end
            end else if (busy) begin
                start = 1'($urandom_range(0, 1));
                a = $urandom; b = $urandom; bi = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("rand_done_count", seen, accepted);
        check("rand_queue_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
